// File: rtl/des_pkg.sv
// Shared DES datapath constants plus the Initial Permutation and its inverse,
// so the final-permutation stage and its tests can run round-trip checks.
package des_pkg;

  localparam int BLOCK_W = 64;
  localparam int HALF_W  = 32;

  // Input bit 8k+j goes to output bit IP_BASE[j]-k.
  localparam int IP_BASE [8] = '{39, 7, 47, 15, 55, 23, 63, 31};

  function automatic logic [BLOCK_W-1:0] ip_perm(input logic [BLOCK_W-1:0] x);
    logic [BLOCK_W-1:0] y;
    y = '0;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 8; j++) begin
        y[IP_BASE[j]-k] = x[8*k+j];
      end
    end
    return y;
  endfunction

  function automatic logic [BLOCK_W-1:0] fp_perm(input logic [BLOCK_W-1:0] y);
    logic [BLOCK_W-1:0] x;
    x = '0;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 8; j++) begin
        x[8*k+j] = y[IP_BASE[j]-k];
      end
    end
    return x;
  endfunction

  function automatic int cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/des_ip_perm.sv
// Initial Permutation as pure wiring; no logic, only a fixed bit shuffle.
module des_ip_perm
  import des_pkg::*;
(
  input  logic [BLOCK_W-1:0] blk,
  output logic [BLOCK_W-1:0] perm
);

  for (genvar gi = 0; gi < 8; gi++) begin : g_byte
    for (genvar gj = 0; gj < 8; gj++) begin : g_bit
      assign perm[IP_BASE[gj]-gi] = blk[8*gi+gj];
    end
  end

endmodule

// File: rtl/des_ip_loader.sv
// DES front end: assembles IN_W-bit words into 64-bit blocks, applies IP and
// holds L0/R0 in a valid/ready output register. Optional flush: DES_IP_FLUSH_EN.
module des_ip_loader
  import des_pkg::*;
#(
  parameter int IN_W = 8
) (
`ifdef DES_IP_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [HALF_W-1:0] l_out,
  output logic [HALF_W-1:0] r_out,
  output logic              busy
);

  localparam int BEATS = BLOCK_W / IN_W;
  localparam int CNT_W = cnt_width(BEATS);

  logic [CNT_W-1:0]   count_reg, count_next;
  logic [BLOCK_W-1:0] asm_reg, asm_next;
  logic [BLOCK_W-1:0] out_reg, out_next;
  logic               out_valid_reg, out_valid_next;
  logic [BLOCK_W-1:0] block, perm;
  logic               last_beat, in_xfer, out_xfer, flush_req;

`ifdef DES_IP_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  assign last_beat = (count_reg == CNT_W'(BEATS - 1));
  assign out_xfer  = out_valid_reg && out_ready;
  // Only the closing beat can stall; earlier beats keep assembling behind a held output.
  assign in_ready  = !flush_req && !(last_beat && out_valid_reg && !out_ready);
  assign in_xfer   = in_valid && in_ready;

  // Full block as it would stand after this beat, MSB word first.
  assign block = (asm_reg << IN_W) | BLOCK_W'(in_data);

  des_ip_perm u_perm (
    .blk  (block),
    .perm (perm)
  );

  always_comb begin
    count_next     = count_reg;
    asm_next       = asm_reg;
    out_next       = out_reg;
    out_valid_next = out_valid_reg;
    if (flush_req) begin
      count_next = '0;
      asm_next   = '0;
    end else if (in_xfer) begin
      asm_next   = block;
      count_next = last_beat ? '0 : count_reg + CNT_W'(1);
    end
    // A new block loading on the same edge as a consume keeps out_valid high.
    if (in_xfer && last_beat) begin
      out_next       = perm;
      out_valid_next = 1'b1;
    end else if (out_xfer) begin
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg     <= '0;
      asm_reg       <= '0;
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      count_reg     <= count_next;
      asm_reg       <= asm_next;
      out_reg       <= out_next;
      out_valid_reg <= out_valid_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign l_out     = out_reg[BLOCK_W-1:HALF_W];
  assign r_out     = out_reg[HALF_W-1:0];
  assign busy      = (count_reg != '0);

endmodule

// File: tb/tb_des_ip_loader.sv
// Scoreboard bench for des_ip_loader (IN_W=8): blocks are queued on their last
// beat and checked through an independent inverse permutation on each consume.
module tb_des_ip_loader;

  localparam int IN_W = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [IN_W-1:0] in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [31:0]     l_out, r_out;
  logic            busy;
`ifdef DES_IP_FLUSH_EN
  logic            flush = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  int pops  = 0;
  int cycles = 0;
  logic [63:0] sb[$];

  des_ip_loader #(.IN_W(IN_W)) dut (
`ifdef DES_IP_FLUSH_EN
    .flush     (flush),
`endif
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .l_out     (l_out),
    .r_out     (r_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycles <= cycles + 1;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  // Inverse of IP from its own table: output bit b[j]-k came from input bit 8k+j.
  function automatic logic [63:0] tb_fp(input logic [63:0] y);
    int b [8] = '{39, 7, 47, 15, 55, 23, 63, 31};
    logic [63:0] x;
    x = '0;
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < 8; j++)
        x[8*k+j] = y[b[j]-k];
    return x;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_value("sb_underflow", 64'd1, 64'd0);
      end else begin
        logic [63:0] exp;
        exp = sb.pop_front();
        check_value("sb_block", tb_fp({l_out, r_out}), exp);
        $display("[TB] consumed block %h", exp);
        pops++;
      end
    end
  end

  task automatic send_word(input logic [IN_W-1:0] d);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_value("in_ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 'x;
  endtask

  task automatic send_block(input logic [63:0] blk);
    for (int i = 0; i < 8; i++) send_word(blk[63-8*i -: 8]);
    sb.push_back(blk);
  endtask

  initial begin
    logic [63:0] a, bb;
    int t0;

    repeat (2) @(posedge clk);
    #1;
    check_value("rst_valid", 64'(out_valid), 64'd0);
    check_value("rst_l", 64'(l_out), 64'd0);
    check_value("rst_r", 64'(r_out), 64'd0);
    check_value("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    #1;
    check_value("rst_in_ready", 64'(in_ready), 64'd1);

    out_ready = 1'b1;
    send_block(64'h0000_0000_0000_0001);
    check_value("bit0_valid", 64'(out_valid), 64'd1);
    check_value("bit0_l", 64'(l_out), 64'h0000_0080);
    check_value("bit0_r", 64'(r_out), 64'h0000_0000);

    send_block(64'h8000_0000_0000_0000);
    check_value("bit63_l", 64'(l_out), 64'h0000_0000);
    check_value("bit63_r", 64'(r_out), 64'h0100_0000);

    send_block(64'hFFFF_FFFF_FFFF_FFFF);
    check_value("ones_l", 64'(l_out), 64'hFFFF_FFFF);
    check_value("ones_r", 64'(r_out), 64'hFFFF_FFFF);
    @(posedge clk);
    #1;

    // Held output: B assembles behind A, only its final beat stalls.
    out_ready = 1'b0;
    a  = {$urandom, $urandom};
    bb = {$urandom, $urandom};
    send_block(a);
    for (int i = 0; i < 7; i++) send_word(bb[63-8*i -: 8]);
    check_value("hold_busy", 64'(busy), 64'd1);
    in_valid = 1'b1;
    in_data  = bb[7:0];
    repeat (2) begin
      @(negedge clk);
      check_value("hold_in_ready", 64'(in_ready), 64'd0);
      check_value("hold_valid", 64'(out_valid), 64'd1);
      check_value("hold_keep_a", tb_fp({l_out, r_out}), a);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check_value("release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sb.push_back(bb);
    check_value("swap_valid", 64'(out_valid), 64'd1);
    check_value("swap_b", tb_fp({l_out, r_out}), bb);
    check_value("swap_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;

    // Full-throughput random stream.
    pops = 0;
    t0 = cycles;
    for (int v = 0; v < 1000; v++) send_block({$urandom, $urandom});
    check_value("stream_cycles", 64'(cycles - t0), 64'd8000);
    @(posedge clk);
    #1;
    check_value("stream_pops", 64'(pops), 64'd1000);

    // Reset mid-block discards the partial and the held block.
    out_ready = 1'b0;
    send_block({$urandom, $urandom});
    for (int i = 0; i < 4; i++) send_word(8'($urandom));
    check_value("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    sb.delete();
    check_value("mid_rst_busy", 64'(busy), 64'd0);
    check_value("mid_rst_valid", 64'(out_valid), 64'd0);
    check_value("mid_rst_l", 64'(l_out), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send_block(64'h0123_4567_89AB_CDEF);
    check_value("post_rst_valid", 64'(out_valid), 64'd1);
    check_value("post_rst_block", tb_fp({l_out, r_out}), 64'h0123_4567_89AB_CDEF);
    @(posedge clk);
    #1;

`ifdef DES_IP_FLUSH_EN
    out_ready = 1'b0;
    a = {$urandom, $urandom};
    send_block(a);
    for (int i = 0; i < 3; i++) send_word(8'($urandom));
    check_value("fl_busy_pre", 64'(busy), 64'd1);
    flush = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hA5;
    @(negedge clk);
    check_value("fl_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check_value("fl_busy", 64'(busy), 64'd0);
    check_value("fl_valid", 64'(out_valid), 64'd1);
    check_value("fl_keep", tb_fp({l_out, r_out}), a);
    out_ready = 1'b1;
    bb = {$urandom, $urandom};
    send_block(bb);
    check_value("fl_next", tb_fp({l_out, r_out}), bb);
    @(posedge clk);
    #1;
`endif

    repeat (3) @(posedge clk);
    #1;
    check_value("sb_drain", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/des_ip_loader.md
Name: des_ip_loader

Overview:
- Front end of the DES datapath.
- Accepts plaintext/ciphertext as a narrow word stream and assembles each 64-bit block.
- Applies the Initial Permutation (IP), the exact inverse of the final permutation (FP) stage that closes the datapath.
- Presents the permuted block as L0/R0 halves to the round engine through a valid/ready output register.

Parameters:
- IN_W, 8, input word width; legal values 8, 16, 32, 64.
- BEATS, 64/IN_W (localparam), words per block.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input word valid
- in_ready  output  1  loader can accept a word this cycle
- in_data  input  IN_W  input word; first word of a block lands in bits [63:64-IN_W]
- out_valid  output  1  permuted block held
- out_ready  input  1  round engine accepts the block
- l_out  output  32  ip[63:32]
- r_out  output  32  ip[31:0]
- busy  output  1  partial block in assembly (beat count != 0)

Behaviour:
- Single clock domain.
- rst_n low (asynchronous): beat count=0, assembly reg=0, out_valid=0, l_out=r_out=0, busy=0; in_ready=1 once rst_n deasserts.
- Input transfer occurs when in_valid && in_ready. Each transfer shifts in_data into the assembly reg, MSB word first, and increments the count.
- Count wraps BEATS-1 -> 0 on the last-beat transfer.
- On the last-beat transfer, IP({assembly, in_data}) loads the output reg the same edge and out_valid=1. Latency is 1 cycle from the last-beat transfer to out_valid.
- IP mapping, bit indices LSB=0:
  - Write input bit 8k+j (k,j in 0..7) to output bit B[j]-k.
  - B = {39,7,47,15,55,23,63,31}.
  - FP(IP(x)) == x for all x.
- Output transfer occurs when out_valid && out_ready; out_valid clears unless a new block loads the same edge.
- l_out/r_out hold stable while out_valid && !out_ready.
- in_ready = !(count==BEATS-1 && out_valid && !out_ready):
  - Non-final beats are always accepted, so the next block assembles while the output is held.
  - Only the final beat stalls.
- Simultaneous output transfer and last-beat transfer: the new block replaces the old one and out_valid stays 1, giving full throughput.
- IN_W=64: every transfer is a last beat; busy is always 0.
- Reset mid-block discards the partial block and any held output.
- in_data ignored when no transfer occurs.
- No arithmetic beyond the wrapping count; count width is clog2(BEATS), minimum 1.

Optional Feature:
- Macro DES_IP_FLUSH_EN.
- Defined:
  - Adds port flush (input, 1, synchronous).
  - flush=1 clears the count and assembly reg next edge and blocks any input transfer that cycle (in_ready=0).
  - Output reg and out_valid are unaffected.
- Undefined: no flush port; behaviour as above.

Decomposition:
- Package des_pkg holds:
  - BLOCK_W=64 and HALF_W=32.
  - IP base table B as a localparam array.
  - A function ip_perm(logic [63:0]) that the FP stage's tests can also use for round-trip checks.
- One combinational sub-module, des_ip_perm (64-bit in/out, pure wiring per the table), instantiated at the output register input. The loader holds all sequential logic.

Test Plan:
- IN_W=8; send bytes 00×7 then 01 (block bit 0 set), out_ready=1 -> one cycle after 8th byte: out_valid=1, l_out=0x00000080, r_out=0x00000000.
- Send 01 then 00×7 (bit 63 set) -> l_out=0x00000000, r_out=0x01000000. Then send FF×8 -> l_out=r_out=0xFFFFFFFF.
- Hold out_ready=0 after block A; stream block B:
  - 7 bytes accepted, in_ready=0 on the 8th, l_out/r_out keep A.
  - Raise out_ready: A consumed and B's 8th byte accepted the same edge; B appears next cycle with out_valid continuous.
- Back-to-back random blocks, out_ready=1 -> one block per 8 cycles; FP(l_out,r_out) equals the sent block (from des_pkg) for 1000 vectors.
- Assert rst_n low after 4 bytes -> count=0, busy=0, out_valid=0 immediately; next 8 bytes form a clean block.
- With DES_IP_FLUSH_EN: flush after 3 bytes while out_valid=1 held -> busy=0, held block unchanged; next 8 bytes produce the correct IP.
